fifo_line_reader: RTL and testbench

Pop-side controller for the image-line `fifo`. It issues single-cycle pop strobes and captures each returned word into a 2-entry skid buffer. It presents the words downstream on a valid/ready stream, tagged with line-end and frame-end markers from column and row counters. It sits between the line FIFO and the next 2D filter stage, and sustains one pixel per clock when the FIFO is non-empty and downstream is ready.

---
 rtl/image_proc_pkg.sv | 31 +++
 rtl/stream_skid_buffer.sv | 64 ++++++
 rtl/fifo_line_reader.sv | 147 ++++++++++++++
 tb/tb_fifo_line_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_proc_pkg.sv
// image_proc_pkg: definitions shared by the image-processing line stages.
//   reader_state_t     : line-reader FSM states (IDLE, STREAM, DRAIN, FLUSH)
//   DEFAULT_LINE_WIDTH : default pixels per line, reused by the filter stages
//   DEFAULT_LINE_COUNT : default lines per frame, reused by the filter stages
//   clog2()            : counter width helper, never returns less than 1
package image_proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FLUSH  = 2'd3
  } reader_state_t;

  localparam int DEFAULT_LINE_WIDTH = 640;
  localparam int DEFAULT_LINE_COUNT = 480;

  // A single-line frame (LINE_COUNT = 1) still needs a 1-bit row counter,
  // so the result is clamped to at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry registered FIFO with valid/ready on both sides.
//   clock, reset         : clock and synchronous active-high reset
//   flush                : synchronous discard of all stored entries
//   in_data/in_valid     : upstream word; in_ready is high when a slot is free
//   out_data/out_valid   : head entry, held stable until out_ready accepts it
//   out_ready            : downstream accepts the head entry
module stream_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       level_reg;
  logic             push;
  logic             pop;

  assign in_ready  = (level_reg != 2'd2);
  assign out_valid = (level_reg != 2'd0);
  assign out_data  = head_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head register only changes when it is consumed or when it is empty,
  // which keeps out_data stable under backpressure.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      level_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level_reg == 2'd0) head_reg <= in_data;
          else                   tail_reg <= in_data;
          level_reg <= level_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          level_reg <= level_reg - 2'd1;
        end
        2'b11: begin
          if (level_reg == 2'd1) begin
            head_reg <= in_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_line_reader.sv
// fifo_line_reader: pop-side controller for the image-line FIFO.
//   clock, reset          : clock and synchronous active-high reset
//   enable                : permits new pops; low pauses without losing position
//   clear                 : synchronous flush (wins over enable)
//   fifo_ready            : FIFO non-empty (may lag a pop by one cycle)
//   fifo_data             : FIFO read data, valid the cycle after fifo_pop
//   fifo_popped_last      : the returning word emptied the FIFO
//   fifo_pop, fifo_clear  : one-cycle pop strobe / one-cycle FIFO clear
//   out_data/out_valid/out_ready : downstream pixel stream
//   out_line_end/out_frame_end   : last pixel of line / of frame
//   frame_done            : one-cycle pulse after the frame-end transfer
module fifo_line_reader
  import image_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int LINE_COUNT = DEFAULT_LINE_COUNT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  fifo_ready,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_popped_last,
  output logic                  fifo_pop,
  output logic                  fifo_clear,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_line_end,
  output logic                  out_frame_end,
  output logic                  frame_done
);

  localparam int COL_W = clog2(LINE_WIDTH);
  localparam int ROW_W = clog2(LINE_COUNT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINE_COUNT - 1);

  reader_state_t         state_reg, state_next;
  logic                  in_flight_reg;
  logic [COL_W-1:0]      col_reg;
  logic [ROW_W-1:0]      row_reg;
  logic                  frame_done_reg;

  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic [DATA_WIDTH+1:0] skid_in_word;
  logic [DATA_WIDTH+1:0] skid_out_word;
  logic [2:0]            buffered;
  logic [2:0]            occupancy;
  logic                  xfer;
  logic                  line_end_tag;
  logic                  frame_end_tag;

  // Each captured word is tagged with its line/frame position as it enters
  // the skid buffer. Every captured word leaves in order exactly once (or is
  // discarded together with the counters on flush), so the capture position
  // equals the position of the pixel at the output; carrying the tags with
  // the data keeps them stable under backpressure for free.
  assign line_end_tag  = (col_reg == COL_LAST);
  assign frame_end_tag = line_end_tag & (row_reg == ROW_LAST);
  assign skid_in_word  = {line_end_tag, frame_end_tag, fifo_data};

  stream_skid_buffer #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear),
    .in_data   (skid_in_word),
    .in_valid  (in_flight_reg),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out_word),
    .out_valid (skid_out_valid),
    .out_ready (out_ready)
  );

  assign out_valid     = skid_out_valid;
  assign out_data      = skid_out_word[DATA_WIDTH-1:0];
  assign out_frame_end = skid_out_valid & skid_out_word[DATA_WIDTH];
  assign out_line_end  = skid_out_valid & skid_out_word[DATA_WIDTH+1];
  assign frame_done    = frame_done_reg;
  assign xfer          = skid_out_valid & out_ready;

  // Buffer fill recovered from the skid handshake flags.
  assign buffered  = !skid_out_valid ? 3'd0 : (skid_in_ready ? 3'd1 : 3'd2);
  // A word leaving this cycle frees its slot in time for a word popped now,
  // which is what lets the stream sustain one pixel per clock.
  assign occupancy = buffered + {2'b00, in_flight_reg} - {2'b00, xfer};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_FLUSH;
    end else begin
      case (state_reg)
        ST_IDLE:   if (enable) state_next = ST_STREAM;
        ST_STREAM: if (!enable) state_next = ST_DRAIN;
        ST_DRAIN: begin
          if (enable)                                      state_next = ST_STREAM;
          else if (!skid_out_valid && !in_flight_reg)      state_next = ST_IDLE;
        end
        ST_FLUSH:  state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic. fifo_ready may still read high the cycle after the last
  // word was popped; the returning word's popped_last flag closes that gap.
  always_comb begin
    fifo_clear = (state_reg == ST_FLUSH);
    fifo_pop   = (state_reg == ST_STREAM) && fifo_ready && (occupancy < 3'd2)
                 && !(in_flight_reg && fifo_popped_last) && !clear;
  end

  // Credit, position counters and frame_done pulse
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      in_flight_reg  <= 1'b0;
      col_reg        <= '0;
      row_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      in_flight_reg  <= fifo_pop;
      frame_done_reg <= xfer & out_frame_end;
      if (in_flight_reg) begin
        if (line_end_tag) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_line_reader.sv
module tb_fifo_line_reader;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int LC = 2;

  logic          clock = 1'b0;
  logic          reset, enable, clear, out_ready;
  logic          fifo_ready = 1'b0;
  logic          fifo_popped_last = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_pop, fifo_clear, out_valid, out_line_end, out_frame_end, frame_done;
  logic [DW-1:0] out_data;

  always #5 clock = ~clock;

  fifo_line_reader #(
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW),
    .LINE_COUNT (LC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .clear            (clear),
    .fifo_ready       (fifo_ready),
    .fifo_data        (fifo_data),
    .fifo_popped_last (fifo_popped_last),
    .fifo_pop         (fifo_pop),
    .fifo_clear       (fifo_clear),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_line_end     (out_line_end),
    .out_frame_end    (out_frame_end),
    .frame_done       (frame_done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          le;
    logic          fe;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pop_cnt = 0;
  int            xfer_cnt = 0;
  int            cycle = 0;
  int            pos = 0;
  int            xfer_cyc[$];

  // FIFO model: registered read data; fifo_ready reflects the fill before the
  // pop of the same edge, so it lags an emptying pop by one cycle.
  always @(posedge clock) begin
    logic [DW-1:0] w;
    cycle++;
    if (reset || fifo_clear) begin
      fifo_q.delete();
      fifo_ready       <= 1'b0;
      fifo_popped_last <= 1'b0;
    end else begin
      fifo_ready       <= (fifo_q.size() > 0);
      fifo_popped_last <= 1'b0;
      if (fifo_pop) begin
        pop_cnt++;
        checks++;
        if (fifo_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty cycle=%0d fifo_pop=1 required fifo non-empty", cycle);
        end else begin
          w = fifo_q.pop_front();
          fifo_data        <= w;
          fifo_popped_last <= (fifo_q.size() == 0);
        end
      end
    end
  end

  // Monitor / scoreboard
  logic          fd_pending = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW+1:0] stall_word = '0;

  always @(negedge clock) begin
    exp_t e;
    if (fd_pending) begin
      checks++;
      if (frame_done !== 1'b1) begin
        errors++;
        $display("FAIL frame_done actual=%0b required=1", frame_done);
      end
      fd_pending = 1'b0;
    end else if (frame_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_spurious actual=1 required=0 cycle=%0d", cycle);
    end
    if (stall_prev) begin
      checks++;
      if (!out_valid || {out_data, out_line_end, out_frame_end} !== stall_word) begin
        errors++;
        $display("FAIL stall_hold actual=v%0b/0x%0h required=v1/0x%0h",
                 out_valid, {out_data, out_line_end, out_frame_end}, stall_word);
      end
    end
    if (out_valid && out_ready && !reset) begin
      xfer_cnt++;
      xfer_cyc.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer actual=0x%0h required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_line_end, out_frame_end} !== {e.data, e.le, e.fe}) begin
          errors++;
          $display("FAIL xfer actual=0x%0h le=%0b fe=%0b required=0x%0h le=%0b fe=%0b",
                   out_data, out_line_end, out_frame_end, e.data, e.le, e.fe);
        end
      end
      if (out_frame_end) fd_pending = 1'b1;
    end
    stall_prev = out_valid && !out_ready && !clear && !reset;
    stall_word = {out_data, out_line_end, out_frame_end};
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Push words into the FIFO model and their expected tags into the scoreboard.
  task automatic load(input logic [DW-1:0] first, input int n);
    logic [DW-1:0] v;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      v = first + DW'(i);
      fifo_q.push_back(v);
      e.data = v;
      e.le   = ((pos % LW) == LW - 1);
      e.fe   = (pos == LW * LC - 1);
      exp_q.push_back(e);
      pos = (pos + 1) % (LW * LC);
    end
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step();
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout remaining=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_xfers(input int target, input int bound, input string tag);
    int k;
    k = 0;
    while (xfer_cnt < target && k < bound) begin
      step();
      k++;
    end
    checks++;
    if (xfer_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout xfers=%0d required=%0d", tag, xfer_cnt, target);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_valid"},  out_valid, 0);
    chk({tag, "_out_data"},   out_data, 0);
    chk({tag, "_line_end"},   out_line_end, 0);
    chk({tag, "_frame_end"},  out_frame_end, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_fifo_pop"},   fifo_pop, 0);
    chk({tag, "_fifo_clear"}, fifo_clear, 0);
  endtask

  initial begin
    int base;
    int p;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; out_ready = 1'b0;
    step(3);
    chk_outputs_zero("reset");
    reset = 1'b0;
    step();

    // Streaming: two 4-pixel lines back to back
    out_ready = 1'b1;
    load(8'h10, 8);
    step();
    enable = 1'b1;
    xfer_cyc.delete();
    wait_drain(40, "stream");
    chk("stream_count", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) chk("stream_span", xfer_cyc[7] - xfer_cyc[0], 7);
    step(2);

    // Empty edge: single word, fifo_ready lags the emptying pop
    p = pop_cnt;
    load(8'hAA, 1);
    wait_drain(20, "single");
    step(6);
    chk("single_pops", pop_cnt - p, 1);
    chk("single_idle", out_valid, 0);

    // Backpressure mid-line for 5 cycles
    base = xfer_cnt;
    load(8'h20, 8);
    wait_xfers(base + 3, 30, "bp_start");
    out_ready = 1'b0;
    step(2);
    p = pop_cnt;
    step(3);
    chk("bp_no_pop", pop_cnt - p, 0);
    out_ready = 1'b1;
    wait_drain(40, "bp");
    step(2);

    // Flush with two words buffered
    out_ready = 1'b0;
    load(8'h40, 8);
    step(6);
    clear = 1'b1;
    exp_q.delete();
    pos = 0;
    step();
    clear = 1'b0;
    chk("flush_fifo_clear", fifo_clear, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_fifo_pop", fifo_pop, 0);
    step();
    chk("flush_clear_once", fifo_clear, 0);
    out_ready = 1'b1;
    step();
    load(8'h50, 4);
    wait_drain(30, "post_flush");
    step(2);

    // Pause after two pixels of the batch
    base = xfer_cnt;
    load(8'h30, 8);
    wait_xfers(base + 2, 30, "pause_start");
    enable = 1'b0;
    step(2);
    p = pop_cnt;
    step(8);
    chk("pause_no_pop", pop_cnt - p, 0);
    enable = 1'b1;
    wait_drain(40, "pause");
    step(2);

    // Reset mid-frame with words buffered
    out_ready = 1'b0;
    load(8'h60, 4);
    step(5);
    reset = 1'b1;
    exp_q.delete();
    pos = 0;
    step();
    chk_outputs_zero("midreset");
    reset = 1'b0;
    step();
    chk("midreset_fifo_clear", fifo_clear, 0);
    out_ready = 1'b1;
    load(8'h70, 4);
    wait_drain(30, "post_reset");
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
